// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide engine feeding the HI/LO register file.
//
// One operation is accepted in IDLE, iterated for ITER cycles in RUN and presented in the
// single DONE cycle. Exactly one strobe (WriteEn, Madd or Msub) is high during DONE.
//
// Ports:
//   Clk     in   system clock, rising edge
//   Rst     in   asynchronous active-high reset
//   Start   in   operation request, sampled only in IDLE
//   Op      in   3'b000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB
//   A       in   rs operand (multiplicand / dividend)
//   B       in   rt operand (multiplier / divisor)
//   HiData  out  product[63:32] or remainder, held until the next DONE
//   LoData  out  product[31:0] or quotient, held until the next DONE
//   WriteEn out  one-cycle strobe: overwrite HI/LO
//   Madd    out  one-cycle strobe: accumulate-add into HI/LO
//   Msub    out  one-cycle strobe: accumulate-subtract from HI/LO
//   Busy    out  high whenever the FSM is not in IDLE
module mult_div_unit #(
  parameter int unsigned ITER = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HiData,
  output logic [31:0] LoData,
  output logic        WriteEn,
  output logic        Madd,
  output logic        Msub,
  output logic        Busy
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMadd  = 3'b100;
  localparam logic [2:0] OpMsub  = 3'b101;

  localparam logic [5:0] LastCnt = 6'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [2:0]  op_q;
  logic [63:0] acc_q;      // multiply: {partial hi, multiplier}; divide: {remainder, quotient}
  logic [31:0] mcand_q;    // multiplicand magnitude or divisor magnitude
  logic [31:0] a_raw_q;    // raw dividend, returned as HI on divide-by-zero
  logic        neg_lo_q;   // negate product / quotient at fix-up
  logic        neg_hi_q;   // negate remainder at fix-up
  logic        div_zero_q;

  // Operand conditioning at acceptance.
  logic        op_valid, in_signed, in_div;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    op_valid  = !(Op[2] && Op[1]);
    in_signed = (Op == OpMult) || (Op == OpDiv) || (Op == OpMadd) || (Op == OpMsub);
    in_div    = (Op == OpDiv) || (Op == OpDivu);
    mag_a     = (in_signed && A[31]) ? 32'd0 - A : A;
    mag_b     = (in_signed && B[31]) ? 32'd0 - B : B;
  end

  // One iteration of either algorithm.
  logic        is_div;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] acc_step;
  logic        unused_diff_msb;

  always_comb begin
    is_div    = (op_q == OpDiv) || (op_q == OpDivu);
    // Shift-add: add multiplicand into the high half when the current multiplier LSB is set,
    // then shift the whole accumulator right, keeping the carry.
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    // Restoring divide: shift the next dividend bit into the remainder and subtract if it fits.
    // A zero divisor always "fits", which leaves the dividend in HI and all ones in LO.
    div_trial = {acc_q[63:32], acc_q[31]};
    div_ge    = div_trial >= {1'b0, mcand_q};
    div_diff  = div_trial - {1'b0, mcand_q};
    unused_diff_msb = div_diff[32];
    div_next  = {(div_ge ? div_diff[31:0] : div_trial[31:0]), acc_q[30:0], div_ge};
    acc_step  = is_div ? div_next : mul_next;
  end

  // Sign fix-up of the final iteration's result.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] hi_fix, lo_fix;

  always_comb begin
    prod_fix = neg_lo_q ? 64'd0 - acc_step : acc_step;
    quo_fix  = neg_lo_q ? 32'd0 - acc_step[31:0] : acc_step[31:0];
    rem_fix  = neg_hi_q ? 32'd0 - acc_step[63:32] : acc_step[63:32];
    if (!is_div) begin
      hi_fix = prod_fix[63:32];
      lo_fix = prod_fix[31:0];
    end else if (div_zero_q) begin
      hi_fix = a_raw_q;
      lo_fix = 32'hFFFF_FFFF;
    end else begin
      hi_fix = rem_fix;
      lo_fix = quo_fix;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      op_q       <= OpMult;
      acc_q      <= 64'd0;
      mcand_q    <= 32'd0;
      a_raw_q    <= 32'd0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      HiData     <= 32'd0;
      LoData     <= 32'd0;
      WriteEn    <= 1'b0;
      Madd       <= 1'b0;
      Msub       <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      WriteEn <= 1'b0;
      Madd    <= 1'b0;
      Msub    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (Start && op_valid) begin
            state_q    <= StRun;
            Busy       <= 1'b1;
            cnt_q      <= 6'd0;
            op_q       <= Op;
            a_raw_q    <= A;
            div_zero_q <= in_div && (B == 32'd0);
            neg_lo_q   <= in_signed && (A[31] ^ B[31]);
            neg_hi_q   <= in_signed && A[31];
            if (in_div) begin
              acc_q   <= {32'd0, mag_a};
              mcand_q <= mag_b;
            end else begin
              acc_q   <= {32'd0, mag_b};
              mcand_q <= mag_a;
            end
          end
        end
        StRun: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            HiData  <= hi_fix;
            LoData  <= lo_fix;
            WriteEn <= (op_q == OpMult) || (op_q == OpMultu) ||
                       (op_q == OpDiv) || (op_q == OpDivu);
            Madd    <= (op_q == OpMadd);
            Msub    <= (op_q == OpMsub);
          end
        end
        StDone: begin
          state_q <= StIdle;
          Busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic [31:0] HiData, LoData;
  logic        WriteEn, Madd, Msub, Busy;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.ITER(32)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .HiData (HiData),
    .LoData (LoData),
    .WriteEn(WriteEn),
    .Madd   (Madd),
    .Msub   (Msub),
    .Busy   (Busy)
  );

  always #5 Clk = ~Clk;

  // Directed vectors: op, A, B, expected HI, expected LO.
  localparam logic [2:0]  DOP [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd4, 3'd5};
  localparam logic [31:0] DA  [8] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd100,
                                      32'd5, 32'h80000000, 32'd3, 32'hFFFFFFFF};
  localparam logic [31:0] DB  [8] = '{32'd7, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF,
                                      32'd4, 32'd1};
  localparam logic [31:0] DHI [8] = '{32'hFFFFFFFF, 32'h00000006, 32'hFFFFFFFF, 32'd2,
                                      32'd5, 32'd0, 32'd0, 32'hFFFFFFFF};
  localparam logic [31:0] DLO [8] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'hFFFFFFFD, 32'd14,
                                      32'hFFFFFFFF, 32'h80000000, 32'd12, 32'hFFFFFFFF};

  // Reference result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (op)
      3'd0, 3'd4, 3'd5: p = sa * sb;
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] ref_strobe(input logic [2:0] op);
    if (op == 3'd4) return 3'b010;
    if (op == 3'd5) return 3'b100;
    return 3'b001;
  endfunction

  // Issue one op and observe 40 cycles. Cycle k is the cycle after the k-th edge following
  // the accepting edge. Start is re-pulsed with junk operands at cycles inj1 and inj2.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj1, input int inj2,
                       output int busy_cnt, output int strobe_cnt, output int strobe_at,
                       output logic [2:0] kind, output logic [31:0] hi, output logic [31:0] lo);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0; A = $urandom; B = $urandom; Op = 3'($urandom_range(0, 5));
    busy_cnt = 0; strobe_cnt = 0; strobe_at = -1; kind = 3'b000; hi = 32'd0; lo = 32'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Busy) busy_cnt++;
      if (WriteEn || Madd || Msub) begin
        strobe_cnt++;
        strobe_at = k;
        kind = {Msub, Madd, WriteEn};
        hi = HiData;
        lo = LoData;
      end
      if (k == inj1 || k == inj2) begin
        Start = 1'b1; A = $urandom; B = $urandom; Op = 3'($urandom_range(0, 5));
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({Busy, WriteEn, Madd, Msub} !== 4'b0000 || HiData !== 32'd0 || LoData !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy/we/madd/msub=%b hi=%h lo=%h, expected 0000 0 0",
               {Busy, WriteEn, Madd, Msub}, HiData, LoData);
    end
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_directed;
    int busy_cnt, strobe_cnt, strobe_at;
    logic [2:0] kind;
    logic [31:0] hi, lo;
    for (int i = 0; i < 8; i++) begin
      do_op(DOP[i], DA[i], DB[i], -1, -1, busy_cnt, strobe_cnt, strobe_at, kind, hi, lo);
      n_checks++;
      if (hi !== DHI[i] || lo !== DLO[i]) begin
        n_fail++;
        $display("FAIL directed_%0d data: got hi=%h lo=%h, expected hi=%h lo=%h",
                 i, hi, lo, DHI[i], DLO[i]);
      end
      n_checks++;
      if (kind !== ref_strobe(DOP[i]) || strobe_cnt != 1 || strobe_at != 32) begin
        n_fail++;
        $display("FAIL directed_%0d strobe: got kind=%b count=%0d at=%0d, expected %b 1 32",
                 i, kind, strobe_cnt, strobe_at, ref_strobe(DOP[i]));
      end
      n_checks++;
      if (busy_cnt != 33) begin
        n_fail++;
        $display("FAIL directed_%0d busy_cycles: got %0d expected 33", i, busy_cnt);
      end
    end
  endtask

  task automatic test_random;
    int busy_cnt, strobe_cnt, strobe_at;
    logic [2:0] kind, op;
    logic [31:0] hi, lo, a, b;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 300));
        3: b = 32'd0 - 32'($urandom_range(1, 300));
        default: ;
      endcase
      exp = ref_result(op, a, b);
      do_op(op, a, b, -1, -1, busy_cnt, strobe_cnt, strobe_at, kind, hi, lo);
      n_checks++;
      if ({hi, lo} !== exp || kind !== ref_strobe(op) || strobe_cnt != 1 || busy_cnt != 33) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h kind=%b n=%0d busy=%0d, expected %h %b 1 33",
                 i, op, a, b, {hi, lo}, kind, strobe_cnt, busy_cnt, exp, ref_strobe(op));
      end
    end
  endtask

  task automatic test_ignore_start;
    int busy_cnt, strobe_cnt, strobe_at;
    logic [2:0] kind;
    logic [31:0] hi, lo;
    logic [63:0] exp;
    exp = ref_result(3'd0, 32'h12345678, 32'hF0F0F0F1);
    do_op(3'd0, 32'h12345678, 32'hF0F0F0F1, 5, 32, busy_cnt, strobe_cnt, strobe_at, kind, hi, lo);
    n_checks++;
    if ({hi, lo} !== exp || strobe_cnt != 1 || busy_cnt != 33) begin
      n_fail++;
      $display("FAIL ignore_start: got %h n=%0d busy=%0d, expected %h 1 33",
               {hi, lo}, strobe_cnt, busy_cnt, exp);
    end
    n_checks++;
    if ({HiData, LoData} !== exp) begin
      n_fail++;
      $display("FAIL hold_result: got %h expected %h", {HiData, LoData}, exp);
    end
  endtask

  task automatic test_back_to_back;
    int first_at, second_at, n_strobe;
    logic [31:0] hi2, lo2;
    logic [63:0] exp2;
    first_at = -1; second_at = -1; n_strobe = 0; hi2 = 32'd0; lo2 = 32'd0;
    exp2 = ref_result(3'd3, 32'd1000, 32'd33);
    @(negedge Clk);
    Start = 1'b1; Op = 3'd1; A = 32'd9; B = 32'd9;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int k = 0; k < 76; k++) begin
      @(negedge Clk);
      if (WriteEn || Madd || Msub) begin
        n_strobe++;
        if (first_at < 0) first_at = k;
        else begin
          second_at = k;
          hi2 = HiData;
          lo2 = LoData;
        end
      end
      if (k == 33) begin
        Start = 1'b1; Op = 3'd3; A = 32'd1000; B = 32'd33;
      end else begin
        Start = 1'b0;
      end
    end
    n_checks++;
    if (n_strobe != 2 || second_at - first_at != 34) begin
      n_fail++;
      $display("FAIL back_to_back timing: got %0d strobes gap=%0d, expected 2 strobes gap=34",
               n_strobe, second_at - first_at);
    end
    n_checks++;
    if ({hi2, lo2} !== exp2) begin
      n_fail++;
      $display("FAIL back_to_back data: got %h expected %h", {hi2, lo2}, exp2);
    end
  endtask

  task automatic test_abort;
    int busy_cnt, strobe_cnt, strobe_at;
    logic [2:0] kind;
    logic [31:0] hi, lo;
    // Leave a non-zero result in HI/LO first so the clear is observable.
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, busy_cnt, strobe_cnt, strobe_at, kind, hi, lo);
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'h7FFF0001; B = 32'h00031234;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (10) @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    n_checks++;
    if (Busy !== 1'b0 || HiData !== 32'd0 || LoData !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_reset: got busy=%b hi=%h lo=%h, expected 0 0 0", Busy, HiData, LoData);
    end
    @(negedge Clk);
    Rst = 1'b0;
    strobe_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (WriteEn || Madd || Msub) strobe_cnt++;
      if (Busy) busy_cnt++;
    end
    n_checks++;
    if (strobe_cnt != 0 || busy_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_no_strobe: got strobes=%0d busy=%0d, expected 0 0",
               strobe_cnt, busy_cnt);
    end
  endtask

  task automatic test_reserved;
    int busy_cnt, strobe_cnt;
    busy_cnt = 0; strobe_cnt = 0;
    @(negedge Clk);
    Start = 1'b1; Op = 3'b111; A = 32'd3; B = 32'd4;
    @(negedge Clk);
    Op = 3'b110;
    @(negedge Clk);
    Start = 1'b0;
    for (int k = 0; k < 36; k++) begin
      if (Busy) busy_cnt++;
      if (WriteEn || Madd || Msub) strobe_cnt++;
      @(negedge Clk);
    end
    n_checks++;
    if (busy_cnt != 0 || strobe_cnt != 0) begin
      n_fail++;
      $display("FAIL reserved_op: got busy=%0d strobes=%0d, expected 0 0", busy_cnt, strobe_cnt);
    end
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_random;
    test_abort;
    test_reserved;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
